// File: rtl/lfsr_descrambler_p_if.sv
// Receive-stream bundle for lfsr_descrambler_p: scrambled word in, descrambled word out.
// Handshake: a word transfers on every clock edge where i_valid is high; there is no ready/backpressure.
interface lfsr_descrambler_p_if #(
  parameter int P_DATA_WIDTH = 32
);
  logic                        i_valid;
  logic                        i_reseed;
  logic [P_DATA_WIDTH-1:0]     i_scr_data;
  logic [P_DATA_WIDTH/8-1:0]   i_scr_char;
  logic                        o_valid;
  logic [P_DATA_WIDTH-1:0]     o_data;
  logic [P_DATA_WIDTH/8-1:0]   o_char;

  modport master (
    output i_valid, i_reseed, i_scr_data, i_scr_char,
    input  o_valid, o_data, o_char
  );

  modport slave (
    input  i_valid, i_reseed, i_scr_data, i_scr_char,
    output o_valid, o_data, o_char
  );
endinterface

// File: rtl/lfsr_descrambler_p.sv
// Parametrised additive / self-synchronising LFSR descrambler with one-cycle registered output.
// Optional feature macro: DESCR_BYPASS_EN adds the i_bypass port (pass-through of scrambled data).
module lfsr_descrambler_p #(
  parameter int                    P_DATA_WIDTH = 32,
  parameter int                    P_LFSR_LEN   = 16,
  parameter logic [P_LFSR_LEN-1:0] P_TAPS       = 16'hA011,
  parameter logic [P_LFSR_LEN-1:0] P_INIT_VALUE = 16'h76D8,
  parameter int                    P_MODE       = 0
) (
  input  logic i_clk,
  input  logic i_rst,
`ifdef DESCR_BYPASS_EN
  input  logic i_bypass,
`endif
  lfsr_descrambler_p_if.slave bus
);
  localparam int W  = P_DATA_WIDTH;
  localparam int L  = P_LFSR_LEN;
  localparam int CW = P_DATA_WIDTH / 8;

  logic [L-1:0]   s_q;
  logic [L-1:0]   s_nxt;
  logic [L-1:0]   seed;
  logic [L+W-1:0] ext;
  logic [W-1:0]   fb;
  logic [W-1:0]   dout;
  logic           bypass;
  logic           reseed_add;

  // Builds the extended vector: low L bits are the state, upper W bits are either
  // generated LFSR bits (additive) or the received bits (self-sync).
  function automatic logic [L+W-1:0] extend(input logic [L-1:0] s, input logic [W-1:0] d);
    logic [L+W-1:0] e;
    e        = '0;
    e[L-1:0] = s;
    for (int i = 0; i < W; i++) begin
      if (P_MODE == 0) e[L+i] = ^(e[i +: L] & P_TAPS);
      else             e[L+i] = d[i];
    end
    return e;
  endfunction

  always_comb begin
`ifdef DESCR_BYPASS_EN
    bypass = i_bypass;
`else
    bypass = 1'b0;
`endif
    reseed_add = (P_MODE == 0) && bus.i_reseed;
    seed       = reseed_add ? P_INIT_VALUE : s_q;
    ext        = extend(seed, bus.i_scr_data);
    for (int i = 0; i < W; i++) begin
      fb[i] = ^(ext[i +: L] & P_TAPS);
    end
    if (P_MODE == 0) dout = bus.i_scr_data ^ ext[W-1:0];
    else             dout = bus.i_scr_data ^ fb;
    s_nxt = ext[L+W-1:W];
    // Self-sync keeps tracking wire bits during bypass; additive freezes (or reseeds).
    if (bypass) begin
      dout = bus.i_scr_data;
      if (P_MODE == 0) s_nxt = seed;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_q         <= P_INIT_VALUE;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_char  <= '0;
    end else begin
      bus.o_valid <= bus.i_valid;
      if (bus.i_valid) begin
        s_q        <= s_nxt;
        bus.o_data <= dout;
        bus.o_char <= bus.i_scr_char[CW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_lfsr_descrambler_p.sv
// Bench for lfsr_descrambler_p: additive (defaults) and self-sync (W=64, L=58, x^58+x^39+1) instances.
module tb_lfsr_descrambler_p;
  localparam logic [15:0] ADD_INIT = 16'h76D8;
  localparam logic [15:0] ADD_TAPS = 16'hA011;
  localparam logic [57:0] SS_TAPS  = 58'h80001;
  localparam logic [57:0] SS_INIT  = 58'h2A5_5A5A_5A5A_5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] add_tx;
  logic [57:0] ss_tx;
  logic [31:0] add_last_p;
  logic [3:0]  add_last_c;

  lfsr_descrambler_p_if #(.P_DATA_WIDTH(32)) add_if ();
  lfsr_descrambler_p_if #(.P_DATA_WIDTH(64)) ss_if ();

`ifdef DESCR_BYPASS_EN
  logic add_bypass = 1'b0;
  logic ss_bypass  = 1'b0;
`endif

  lfsr_descrambler_p u_add (
    .i_clk (clk),
    .i_rst (rst),
`ifdef DESCR_BYPASS_EN
    .i_bypass (add_bypass),
`endif
    .bus   (add_if.slave)
  );

  lfsr_descrambler_p #(
    .P_DATA_WIDTH (64),
    .P_LFSR_LEN   (58),
    .P_TAPS       (SS_TAPS),
    .P_INIT_VALUE (SS_INIT),
    .P_MODE       (1)
  ) u_ss (
    .i_clk (clk),
    .i_rst (rst),
`ifdef DESCR_BYPASS_EN
    .i_bypass (ss_bypass),
`endif
    .bus   (ss_if.slave)
  );

  // Serial (bit-at-a-time) reference scramblers.
  function automatic logic [31:0] add_ks(input logic [15:0] st);
    logic [15:0] h;
    logic [31:0] ks;
    h = st;
    for (int i = 0; i < 32; i++) begin
      ks[i] = h[0];
      h = {^(h & ADD_TAPS), h[15:1]};
    end
    return ks;
  endfunction

  function automatic logic [15:0] add_next(input logic [15:0] st);
    logic [15:0] h;
    h = st;
    for (int i = 0; i < 32; i++) h = {^(h & ADD_TAPS), h[15:1]};
    return h;
  endfunction

  function automatic logic [63:0] ss_scramble(input logic [57:0] hist, input logic [63:0] p);
    logic [57:0] h;
    logic [63:0] s;
    h = hist;
    for (int i = 0; i < 64; i++) begin
      s[i] = p[i] ^ (^(h & SS_TAPS));
      h = {s[i], h[57:1]};
    end
    return s;
  endfunction

  function automatic logic [57:0] ss_hist(input logic [57:0] hist, input logic [63:0] s);
    logic [57:0] h;
    h = hist;
    for (int i = 0; i < 64; i++) h = {s[i], h[57:1]};
    return h;
  endfunction

  task automatic add_drive(input logic v, input logic rs, input logic [31:0] d, input logic [3:0] c);
    add_if.i_valid    = v;
    add_if.i_reseed   = rs;
    add_if.i_scr_data = d;
    add_if.i_scr_char = c;
  endtask

  task automatic ss_drive(input logic v, input logic rs, input logic [63:0] d, input logic [7:0] c);
    ss_if.i_valid    = v;
    ss_if.i_reseed   = rs;
    ss_if.i_scr_data = d;
    ss_if.i_scr_char = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_word(input logic [31:0] p, input logic [3:0] c, input logic rs);
    if (rs) add_tx = ADD_INIT;
    add_drive(1'b1, rs, p ^ add_ks(add_tx), c);
    add_tx = add_next(add_tx);
    tick();
    add_drive(1'b0, 1'b0, 32'h0, 4'h0);
    add_last_p = p;
    add_last_c = c;
  endtask

  task automatic ss_word(input logic [63:0] p, input logic [7:0] c, input logic rs);
    logic [63:0] s;
    s = ss_scramble(ss_tx, p);
    ss_tx = ss_hist(ss_tx, s);
    ss_drive(1'b1, rs, s, c);
    tick();
    ss_drive(1'b0, 1'b0, 64'h0, 8'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    add_drive(1'b1, 1'b1, $urandom, 4'hF);
    ss_drive(1'b1, 1'b1, {$urandom, $urandom}, 8'hFF);
    tick();
    tick();
    n_vec++;
    if (add_if.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_add_valid got=%b exp=0", add_if.o_valid); end
    n_vec++;
    if (add_if.o_data !== 32'h0) begin n_err++; $display("FAIL reset_add_data got=%h exp=0", add_if.o_data); end
    n_vec++;
    if (add_if.o_char !== 4'h0) begin n_err++; $display("FAIL reset_add_char got=%h exp=0", add_if.o_char); end
    n_vec++;
    if (ss_if.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_ss_valid got=%b exp=0", ss_if.o_valid); end
    n_vec++;
    if (ss_if.o_data !== 64'h0) begin n_err++; $display("FAIL reset_ss_data got=%h exp=0", ss_if.o_data); end
    n_vec++;
    if (ss_if.o_char !== 8'h0) begin n_err++; $display("FAIL reset_ss_char got=%h exp=0", ss_if.o_char); end
    rst = 1'b0;
    add_drive(1'b0, 1'b0, 32'h0, 4'h0);
    ss_drive(1'b0, 1'b0, 64'h0, 8'h0);
    add_tx = ADD_INIT;
  endtask

  task automatic test_additive_first();
    // All-zero input exposes the raw keystream: seed in the low half, golden LFSR bits above.
    add_drive(1'b1, 1'b0, 32'h0, 4'h5);
    tick();
    n_vec++;
    if (add_if.o_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got=%b exp=1", add_if.o_valid); end
    n_vec++;
    if (add_if.o_data !== 32'h9E62_76D8) begin n_err++; $display("FAIL first_data got=%h exp=9e6276d8", add_if.o_data); end
    n_vec++;
    if (add_if.o_char !== 4'h5) begin n_err++; $display("FAIL first_char got=%h exp=5", add_if.o_char); end
    add_drive(1'b0, 1'b0, 32'h0, 4'h0);
    add_tx = add_next(ADD_INIT);
  endtask

  task automatic test_additive_stream();
    logic [31:0] p;
    logic [3:0]  c;
    for (int w = 0; w < 100; w++) begin
      p = $urandom;
      c = 4'($urandom_range(0, 15));
      add_word(p, c, 1'b0);
      n_vec++;
      if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== {1'b1, p, c}) begin
        n_err++;
        $display("FAIL stream w=%0d got v=%b d=%h c=%h exp v=1 d=%h c=%h", w, add_if.o_valid, add_if.o_data, add_if.o_char, p, c);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    logic [3:0]  c;
    int gap;
    for (int w = 0; w < 20; w++) begin
      p = $urandom;
      c = 4'($urandom_range(0, 15));
      add_word(p, c, 1'b0);
      n_vec++;
      if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== {1'b1, p, c}) begin
        n_err++;
        $display("FAIL stall_word w=%0d got d=%h c=%h exp d=%h c=%h", w, add_if.o_data, add_if.o_char, p, c);
      end
      gap = $urandom_range(1, 5);
      for (int g = 0; g < gap; g++) begin
        // Reseed strobes without valid must leave the state alone.
        add_drive(1'b0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        tick();
        n_vec++;
        if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== {1'b0, add_last_p, add_last_c}) begin
          n_err++;
          $display("FAIL stall_gap w=%0d got v=%b d=%h c=%h exp v=0 d=%h c=%h", w, add_if.o_valid, add_if.o_data, add_if.o_char, add_last_p, add_last_c);
        end
      end
      add_drive(1'b0, 1'b0, 32'h0, 4'h0);
    end
  endtask

  task automatic test_reseed();
    logic [31:0] p;
    logic [3:0]  c;
    for (int w = 0; w < 12; w++) begin
      p = $urandom;
      c = 4'($urandom_range(0, 15));
      add_word(p, c, w == 7);
      n_vec++;
      if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== {1'b1, p, c}) begin
        n_err++;
        $display("FAIL reseed w=%0d got d=%h exp d=%h", w, add_if.o_data, p);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] p;
    logic [3:0]  c;
    for (int w = 0; w < 28; w++) begin
      if (w == 20) begin
        rst = 1'b1;
        add_drive(1'b1, 1'b0, $urandom, 4'($urandom_range(1, 15)));
        tick();
        rst = 1'b0;
        add_drive(1'b0, 1'b0, 32'h0, 4'h0);
        add_tx = ADD_INIT;
        n_vec++;
        if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== 37'h0) begin
          n_err++;
          $display("FAIL reset_mid got v=%b d=%h c=%h exp all zero", add_if.o_valid, add_if.o_data, add_if.o_char);
        end
      end else begin
        p = $urandom;
        c = 4'($urandom_range(0, 15));
        add_word(p, c, 1'b0);
        n_vec++;
        if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== {1'b1, p, c}) begin
          n_err++;
          $display("FAIL reset_mid_stream w=%0d got d=%h exp d=%h", w, add_if.o_data, p);
        end
      end
    end
  endtask

  task automatic test_self_sync();
    logic [63:0] p;
    logic [7:0]  c;
    // Scrambler history deliberately differs from the descrambler's reset seed.
    ss_tx = 58'({$urandom, $urandom});
    if (ss_tx == SS_INIT) ss_tx[0] = ~ss_tx[0];
    for (int w = 0; w < 16; w++) begin
      p = {$urandom, $urandom};
      c = 8'($urandom_range(0, 255));
      ss_word(p, c, (w % 4) == 2);
      n_vec++;
      if ({ss_if.o_valid, ss_if.o_char} !== {1'b1, c}) begin
        n_err++;
        $display("FAIL ss_valid_char w=%0d got v=%b c=%h exp v=1 c=%h", w, ss_if.o_valid, ss_if.o_char, c);
      end
      if (w > 0) begin
        n_vec++;
        if (ss_if.o_data !== p) begin
          n_err++;
          $display("FAIL ss_data w=%0d got=%h exp=%h", w, ss_if.o_data, p);
        end
      end
    end
  endtask

`ifdef DESCR_BYPASS_EN
  task automatic test_bypass_additive();
    logic [31:0] d;
    logic [3:0]  c;
    for (int w = 0; w < 9; w++) begin
      d = $urandom;
      c = 4'($urandom_range(0, 15));
      if (w >= 3 && w <= 5) begin
        add_bypass = 1'b1;
        add_drive(1'b1, 1'b0, d, c);
        tick();
        add_bypass = 1'b0;
        add_drive(1'b0, 1'b0, 32'h0, 4'h0);
      end else begin
        add_word(d, c, 1'b0);
      end
      n_vec++;
      if ({add_if.o_valid, add_if.o_data, add_if.o_char} !== {1'b1, d, c}) begin
        n_err++;
        $display("FAIL bypass_add w=%0d got d=%h exp d=%h", w, add_if.o_data, d);
      end
    end
  endtask

  task automatic test_bypass_self_sync();
    logic [63:0] d;
    logic [7:0]  c;
    for (int w = 0; w < 9; w++) begin
      d = {$urandom, $urandom};
      c = 8'($urandom_range(0, 255));
      if (w >= 3 && w <= 5) begin
        ss_bypass = 1'b1;
        ss_tx = ss_hist(ss_tx, d);
        ss_drive(1'b1, 1'b0, d, c);
        tick();
        ss_bypass = 1'b0;
        ss_drive(1'b0, 1'b0, 64'h0, 8'h0);
      end else begin
        ss_word(d, c, 1'b0);
      end
      n_vec++;
      if ({ss_if.o_valid, ss_if.o_data, ss_if.o_char} !== {1'b1, d, c}) begin
        n_err++;
        $display("FAIL bypass_ss w=%0d got d=%h exp d=%h", w, ss_if.o_data, d);
      end
    end
  endtask
`endif

  initial begin
    add_drive(1'b0, 1'b0, 32'h0, 4'h0);
    ss_drive(1'b0, 1'b0, 64'h0, 8'h0);
    add_last_p = '0;
    add_last_c = '0;
    test_reset();
    test_additive_first();
    test_additive_stream();
    test_stall();
    test_reseed();
    test_reset_mid();
    test_self_sync();
`ifdef DESCR_BYPASS_EN
    test_bypass_additive();
    test_bypass_self_sync();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
